idli_ls_m: RTL and testbench
============================

IDLI_LS_M -- requirements
Module: idli_ls_m

Interface
- REQ-001 SHALL have parameter SLICES, default 4, meaning number of 4b slices per data_t word (16b / 4b); only 4 supported.
- REQ-002 SHALL have i_ls_gck  input  1  clock; one clock domain.
- REQ-003 SHALL have i_ls_rst  input  1  reset, synchronous, active-high.
- REQ-004 SHALL have i_ls_ctr  input  2  global slice counter; value k means the register file presents slice k (bits 4k+3:4k) this cycle.
- REQ-005 SHALL have i_ls_ld_vld  input  1  load request valid.
- REQ-006 SHALL have o_ls_ld_rdy  output  1  load request ready.
- REQ-007 SHALL have i_ls_ld_reg  input  reg_t  destination register of load.
- REQ-008 SHALL have i_ls_ld_data  input  data_t  parallel word to write.
- REQ-009 SHALL have o_ls_rf_dst, o_ls_rf_dst_en, o_ls_rf_dst_data  output  reg_t/1/slice_t  register file write port.
- REQ-010 SHALL have i_ls_st_vld  input  1  store request valid.
- REQ-011 SHALL have o_ls_st_rdy  output  1  store request ready.
- REQ-012 SHALL have i_ls_st_reg  input  reg_t  source register of store.
- REQ-013 SHALL have o_ls_rf_src  output  reg_t  register file read-port select; i_ls_rf_src_data  input  slice_t  returned slice.
- REQ-014 SHALL have o_ls_st_data_vld  output  1, o_ls_st_data  output  data_t, i_ls_st_data_rdy  input  1: assembled word handshake.

Function
- REQ-015 Handshakes SHALL complete on a cycle where vld and rdy are both high; rdy SHALL NOT depend combinationally on vld.
- REQ-016 Load FSM SHALL have states LD_IDLE, LD_WAIT, LD_WRITE; o_ls_ld_rdy high only in LD_IDLE.
- REQ-017 On load handshake SHALL latch reg and data; next state LD_WRITE if i_ls_ctr==3, else LD_WAIT.
- REQ-018 LD_WAIT SHALL move to LD_WRITE on the cycle i_ls_ctr==3.
- REQ-019 In LD_WRITE SHALL drive o_ls_rf_dst_en=1, o_ls_rf_dst=latched reg, o_ls_rf_dst_data=latched word bits 4*ctr+3:4*ctr; exit to LD_IDLE after ctr==3 cycle; exactly 4 write cycles, ctr 0..3 in order.
- REQ-020 Outside LD_WRITE, o_ls_rf_dst_en SHALL be 0 and o_ls_rf_dst_data SHALL be 0.
- REQ-021 Load latency: handshake at ctr=k -> first write at next ctr==0 (1..4 cycles later); back-to-back loads SHALL be accepted the cycle after the last write.
- REQ-022 Store FSM SHALL have states ST_IDLE, ST_WAIT, ST_READ, ST_HOLD; o_ls_st_rdy high only in ST_IDLE.
- REQ-023 On store handshake SHALL latch reg; next state ST_READ if ctr==3, else ST_WAIT; ST_WAIT -> ST_READ when ctr==3.
- REQ-024 o_ls_rf_src SHALL equal latched reg in ST_WAIT and ST_READ, else 0.
- REQ-025 In ST_READ SHALL capture i_ls_rf_src_data into word bits 4*ctr+3:4*ctr; after ctr==3 cycle -> ST_HOLD.
- REQ-026 In ST_HOLD o_ls_st_data_vld=1 and o_ls_st_data stable until i_ls_st_data_rdy; then ST_IDLE; o_ls_st_data_vld=0 in all other states.
- REQ-027 Load and store FSMs SHALL operate independently and concurrently.
- REQ-028 Load and store to same register in the same slice window: store SHALL return the pre-load value.
- REQ-029 Register 0: load SHALL still perform 4 write cycles (ignored by file); store SHALL return 0.

Reset
- REQ-030 Reset SHALL force LD_IDLE and ST_IDLE; o_ls_ld_rdy=1, o_ls_st_rdy=1, o_ls_rf_dst_en=0, o_ls_rf_dst=0, o_ls_rf_dst_data=0, o_ls_rf_src=0, o_ls_st_data_vld=0, o_ls_st_data=0.
- REQ-031 Reset mid-write SHALL abort immediately; partially written register content is undefined; no handshake accepted in a reset cycle.

Structure
- REQ-032 ld_state_t and st_state_t enums SHALL live in idli_pkg alongside reg_t, slice_t, data_t.
- REQ-033 Single module, no sub-module; one always_ff per FSM plus datapath.

Verification
- REQ-034 Load 0xBEEF to R5 accepted at ctr=1 -> dst_en high for ctr 0..3 next window, dst_data F,E,E,B; R5 reads 0xBEEF.
- REQ-035 Store R3 holding 0x1234 accepted at ctr=3 -> vld after 4 cycles, o_ls_st_data=0x1234, held 3 cycles while rdy=0.
- REQ-036 Load 0xAAAA and store of the same R7 (old 0x5555) accepted same cycle -> store returns 0x5555, R7 then 0xAAAA.
- REQ-037 Back-to-back loads 0x0001, 0x8000 to R1, R2 -> second accepted cycle after first's last write, written in following window.
- REQ-038 Reset asserted during second write cycle -> dst_en 0 next cycle, both rdy 1, no vld.
- REQ-039 Store R0 -> o_ls_st_data=0x0000.

Source files
------------

// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types for the idli load/store unit
package idli_pkg;

    localparam int SLICE_W = 4;
    localparam int DATA_W  = 16;

    typedef logic [3:0]         reg_t;
    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WAIT,
        LD_WRITE
    } ld_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_HOLD
    } st_state_t;

endpackage

// File: rtl/idli_ls_m.sv
// rtl/idli_ls_m.sv - load/store unit bridging parallel words and the slice-serial register file
module idli_ls_m
    import idli_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic      i_ls_gck,
    input  logic      i_ls_rst,
    input  logic [1:0] i_ls_ctr,

    input  logic      i_ls_ld_vld,
    output logic      o_ls_ld_rdy,
    input  reg_t      i_ls_ld_reg,
    input  data_t     i_ls_ld_data,

    output reg_t      o_ls_rf_dst,
    output logic      o_ls_rf_dst_en,
    output slice_t    o_ls_rf_dst_data,

    input  logic      i_ls_st_vld,
    output logic      o_ls_st_rdy,
    input  reg_t      i_ls_st_reg,

    output reg_t      o_ls_rf_src,
    input  slice_t    i_ls_rf_src_data,

    output logic      o_ls_st_data_vld,
    output data_t     o_ls_st_data,
    input  logic      i_ls_st_data_rdy
);

    localparam logic [1:0] LAST_SLICE = 2'(SLICES - 1);

    logic last_slice;
    assign last_slice = (i_ls_ctr == LAST_SLICE);

    ld_state_t ld_state, ld_next;
    reg_t      ld_reg;
    data_t     ld_data;

    st_state_t st_state, st_next;
    reg_t      st_reg;
    data_t     st_word;

    always_ff @(posedge i_ls_gck) begin
        if (i_ls_rst) begin
            ld_state <= LD_IDLE;
            ld_reg   <= '0;
            ld_data  <= '0;
        end else begin
            ld_state <= ld_next;
            if (i_ls_ld_vld && o_ls_ld_rdy) begin
                ld_reg  <= i_ls_ld_reg;
                ld_data <= i_ls_ld_data;
            end
        end
    end

    // Writes always start at slice 0, so a load waits for the window boundary.
    always_comb begin
        ld_next          = ld_state;
        o_ls_ld_rdy      = 1'b0;
        o_ls_rf_dst_en   = 1'b0;
        o_ls_rf_dst      = '0;
        o_ls_rf_dst_data = '0;
        case (ld_state)
            LD_IDLE: begin
                o_ls_ld_rdy = 1'b1;
                if (i_ls_ld_vld) ld_next = last_slice ? LD_WRITE : LD_WAIT;
            end
            LD_WAIT: begin
                if (last_slice) ld_next = LD_WRITE;
            end
            LD_WRITE: begin
                o_ls_rf_dst_en   = 1'b1;
                o_ls_rf_dst      = ld_reg;
                o_ls_rf_dst_data = ld_data[{i_ls_ctr, 2'b00} +: SLICE_W];
                if (last_slice) ld_next = LD_IDLE;
            end
            default: ld_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge i_ls_gck) begin
        if (i_ls_rst) begin
            st_state <= ST_IDLE;
            st_reg   <= '0;
            st_word  <= '0;
        end else begin
            st_state <= st_next;
            if (i_ls_st_vld && o_ls_st_rdy) st_reg <= i_ls_st_reg;
            if (st_state == ST_READ) st_word[{i_ls_ctr, 2'b00} +: SLICE_W] <= i_ls_rf_src_data;
        end
    end

    // The file is addressed one cycle early (ST_WAIT) so the read window lines up with slice 0.
    always_comb begin
        st_next          = st_state;
        o_ls_st_rdy      = 1'b0;
        o_ls_rf_src      = '0;
        o_ls_st_data_vld = 1'b0;
        case (st_state)
            ST_IDLE: begin
                o_ls_st_rdy = 1'b1;
                if (i_ls_st_vld) st_next = last_slice ? ST_READ : ST_WAIT;
            end
            ST_WAIT: begin
                o_ls_rf_src = st_reg;
                if (last_slice) st_next = ST_READ;
            end
            ST_READ: begin
                o_ls_rf_src = st_reg;
                if (last_slice) st_next = ST_HOLD;
            end
            ST_HOLD: begin
                o_ls_st_data_vld = 1'b1;
                if (i_ls_st_data_rdy) st_next = ST_IDLE;
            end
            default: st_next = ST_IDLE;
        endcase
    end

    assign o_ls_st_data = st_word;

endmodule

// File: tb/tb_idli_ls_m.sv
// tb/tb_idli_ls_m.sv - scoreboard bench for idli_ls_m with a slice-serial register file model
module tb_idli_ls_m;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctr;
    logic        ld_vld, ld_rdy;
    logic [3:0]  ld_reg;
    logic [15:0] ld_data;
    logic [3:0]  dst;
    logic        dst_en;
    logic [3:0]  dst_data;
    logic        st_vld, st_rdy;
    logic [3:0]  st_reg;
    logic [3:0]  src;
    logic [3:0]  src_data;
    logic        st_data_vld;
    logic [15:0] st_data;
    logic        st_data_rdy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] rf [16];

    typedef struct {
        logic [3:0] r;
        logic [3:0] d;
        int         c;
    } wr_t;

    typedef struct {
        logic [15:0] d;
        int          c;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];
    bit  st_seen = 1'b0;

    idli_ls_m #(.SLICES(4)) dut (
        .i_ls_gck         (clk),
        .i_ls_rst         (rst),
        .i_ls_ctr         (ctr),
        .i_ls_ld_vld      (ld_vld),
        .o_ls_ld_rdy      (ld_rdy),
        .i_ls_ld_reg      (ld_reg),
        .i_ls_ld_data     (ld_data),
        .o_ls_rf_dst      (dst),
        .o_ls_rf_dst_en   (dst_en),
        .o_ls_rf_dst_data (dst_data),
        .i_ls_st_vld      (st_vld),
        .o_ls_st_rdy      (st_rdy),
        .i_ls_st_reg      (st_reg),
        .o_ls_rf_src      (src),
        .i_ls_rf_src_data (src_data),
        .o_ls_st_data_vld (st_data_vld),
        .o_ls_st_data     (st_data),
        .i_ls_st_data_rdy (st_data_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ctr = 2'd0;
        forever begin
            @(posedge clk);
            #1 ctr = ctr + 2'd1;
        end
    end

    // Register file: writes land at the edge, reads are combinational, so a same-slice read sees the old value.
    always @(posedge clk) if (dst_en) rf[dst][{ctr, 2'b00} +: 4] <= dst_data;
    assign src_data = (src == 4'd0) ? 4'h0 : rf[src][{ctr, 2'b00} +: 4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dst_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_dst_en", 32'(dst_en), 32'd0);
                end else begin
                    check("wr_reg", 32'(dst), 32'(wr_q[0].r));
                    check("wr_data", 32'(dst_data), 32'(wr_q[0].d));
                    check("wr_cycle", cyc, wr_q[0].c);
                    void'(wr_q.pop_front());
                end
            end else begin
                check("idle_dst_data", 32'(dst_data), 32'd0);
            end
            if (st_data_vld) begin
                if (st_q.size() == 0) begin
                    check("unexpected_st_vld", 32'(st_data_vld), 32'd0);
                end else begin
                    check("st_data", 32'(st_data), 32'(st_q[0].d));
                    if (!st_seen) check("st_vld_cycle", cyc, st_q[0].c);
                    st_seen = 1'b1;
                    if (st_data_rdy) begin
                        void'(st_q.pop_front());
                        st_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input bit do_ld, input bit do_st, input int k,
                         input logic [3:0] lreg, input logic [15:0] ldata,
                         input logic [3:0] sreg, input logic [15:0] sexp,
                         output int hs_cyc);
        int n = 0;
        int lat;
        @(negedge clk);
        while (!(ctr == 2'(k) && (!do_ld || ld_rdy) && (!do_st || st_rdy)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        hs_cyc = -1;
        if (n >= 100) begin
            check("issue_timeout", 32'(n), 32'd0);
            return;
        end
        hs_cyc = cyc;
        lat = 4 - k;
        if (do_ld) begin
            ld_vld  = 1'b1;
            ld_reg  = lreg;
            ld_data = ldata;
            for (int i = 0; i < 4; i++) wr_q.push_back('{lreg, ldata[4*i +: 4], cyc + lat + i});
        end
        if (do_st) begin
            st_vld = 1'b1;
            st_reg = sreg;
            st_q.push_back('{sexp, cyc + lat + 4});
        end
        @(posedge clk);
        #1;
        ld_vld = 1'b0;
        st_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((wr_q.size() != 0 || st_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int h, h1, h2, n;
        rst = 1'b1;
        ld_vld = 1'b0; ld_reg = '0; ld_data = '0;
        st_vld = 1'b0; st_reg = '0; st_data_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ld_rdy", 32'(ld_rdy), 32'd1);
        check("rst_st_rdy", 32'(st_rdy), 32'd1);
        check("rst_dst_en", 32'(dst_en), 32'd0);
        check("rst_dst", 32'(dst), 32'd0);
        check("rst_dst_data", 32'(dst_data), 32'd0);
        check("rst_src", 32'(src), 32'd0);
        check("rst_st_vld", 32'(st_data_vld), 32'd0);
        check("rst_st_data", 32'(st_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(1, 0, 3, 4'd3, 16'h1234, 4'd0, 16'h0, h); drain();
        issue(1, 0, 0, 4'd7, 16'h5555, 4'd0, 16'h0, h); drain();
        issue(1, 0, 1, 4'd5, 16'hBEEF, 4'd0, 16'h0, h); drain();
        check("rf_r5", 32'(rf[5]), 32'h0000BEEF);

        // Store with the consumer stalled for three valid cycles.
        st_data_rdy = 1'b0;
        issue(0, 1, 3, 4'd0, 16'h0, 4'd3, 16'h1234, h);
        n = 0;
        @(negedge clk);
        while (!st_data_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("st_vld_seen", 32'(st_data_vld), 32'd1);
        repeat (3) @(posedge clk);
        #1 st_data_rdy = 1'b1;
        @(negedge clk);
        check("st_vld_held", 32'(st_data_vld), 32'd1);
        @(negedge clk);
        check("st_vld_dropped", 32'(st_data_vld), 32'd0);
        drain();

        issue(1, 1, 2, 4'd7, 16'hAAAA, 4'd7, 16'h5555, h); drain();
        check("rf_r7", 32'(rf[7]), 32'h0000AAAA);

        issue(1, 0, 1, 4'd1, 16'h0001, 4'd0, 16'h0, h1);
        issue(1, 0, 0, 4'd2, 16'h8000, 4'd0, 16'h0, h2);
        check("b2b_accept_cycle", h2, h1 + 3 + 3 + 1);
        drain();
        check("rf_r1", 32'(rf[1]), 32'h00000001);
        check("rf_r2", 32'(rf[2]), 32'h00008000);
        check("rf_r3", 32'(rf[3]), 32'h00001234);

        issue(0, 1, 0, 4'd0, 16'h0, 4'd0, 16'h0000, h); drain();

        // Reset during the second write slice aborts the load.
        issue(1, 0, 0, 4'd4, 16'h1357, 4'd0, 16'h0, h);
        n = 0;
        @(negedge clk);
        while (!(dst_en && ctr == 2'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("second_write_seen", 32'(dst_en && ctr == 2'd1), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_dst_en", 32'(dst_en), 32'd0);
        check("abort_dst_data", 32'(dst_data), 32'd0);
        check("abort_ld_rdy", 32'(ld_rdy), 32'd1);
        check("abort_st_rdy", 32'(st_rdy), 32'd1);
        check("abort_st_vld", 32'(st_data_vld), 32'd0);
        rst = 1'b0;
        wr_q.delete();
        repeat (8) @(negedge clk);

        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("st_q_empty", 32'(st_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
